tdm_mux8_tx: RTL and testbench

Time-division serializing transmitter: the 8-to-1 counterpart feeding the team's 1-to-8 demux stage. It captures an 8-bit parallel word and emits one bit per slot on a single line. It drives a 3-bit slot select alongside each bit, so the downstream demux routes each bit to the matching output. It sits between parallel channel sources and the shared serial link.

---
 rtl/tdm_mux8_tx_if.sv | 24 ++
 rtl/tdm_mux8_tx.sv | 130 +++++++++++++
 tb/tb_tdm_mux8_tx.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/tdm_mux8_tx_if.sv
// Parallel-side handshake and serial-side slot bus of the 8-to-1 TDM transmitter.
interface tdm_mux8_tx_if;
  logic       EN;
  logic [7:0] din;
  logic       load;
  logic       ready;
  logic       Y;
  logic [2:0] sel;
  logic       valid;
  logic       frame_start;
  logic       done;

  // Channel source / test driver side.
  modport master (
    output EN, din, load,
    input  ready, Y, sel, valid, frame_start, done
  );

  // Transmitter side.
  modport slave (
    input  EN, din, load,
    output ready, Y, sel, valid, frame_start, done
  );
endinterface

// File: rtl/tdm_mux8_tx.sv
// Time-division serializing transmitter: captures an 8-bit word and sends
// bit k in slot k, each slot held SLOT_CYCLES clocks, with the slot index on
// sel so the downstream 1-to-8 demux can route each bit. All outputs are
// registered; a load in the final cycle of slot 7 chains frames without a gap.
module tdm_mux8_tx #(
  parameter int unsigned SLOT_CYCLES = 1,
  parameter int unsigned NUM_CH      = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  tdm_mux8_tx_if.slave bus
);

  localparam int unsigned CW = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(SLOT_CYCLES - 1);
  localparam logic [2:0]    LAST_SEL = 3'(NUM_CH - 1);

  typedef enum logic {IDLE, SEND} state_t;

  state_t        state_q, state_d;
  logic [7:0]    shadow_q, shadow_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    sel_q, sel_d;
  logic [2:0]    sel_inc;
  logic          y_q, y_d;
  logic          valid_q, valid_d;
  logic          fs_q, fs_d;
  logic          done_q, done_d;
  logic          ready_q, ready_d;

  assign sel_inc = sel_q + 3'd1;

  // State and output registers; reset returns the line to idle immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      shadow_q <= '0;
      cnt_q    <= '0;
      sel_q    <= '0;
      y_q      <= 1'b0;
      valid_q  <= 1'b0;
      fs_q     <= 1'b0;
      done_q   <= 1'b0;
      ready_q  <= 1'b1;
    end else begin
      state_q  <= state_d;
      shadow_q <= shadow_d;
      cnt_q    <= cnt_d;
      sel_q    <= sel_d;
      y_q      <= y_d;
      valid_q  <= valid_d;
      fs_q     <= fs_d;
      done_q   <= done_d;
      ready_q  <= ready_d;
    end
  end

  // Next-state and next-output logic; outputs are computed one cycle ahead
  // so that every port comes straight from a flop.
  always_comb begin
    state_d  = state_q;
    shadow_d = shadow_q;
    cnt_d    = cnt_q;
    sel_d    = sel_q;
    y_d      = y_q;
    valid_d  = valid_q;
    fs_d     = 1'b0;
    done_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.load && bus.EN) begin
          state_d  = SEND;
          shadow_d = bus.din;
          cnt_d    = '0;
          sel_d    = '0;
          y_d      = bus.din[0];
          valid_d  = 1'b1;
          fs_d     = 1'b1;
        end else begin
          cnt_d   = '0;
          sel_d   = '0;
          y_d     = 1'b0;
          valid_d = 1'b0;
        end
      end
      SEND: begin
        if (!bus.EN) begin
          state_d = IDLE;
          cnt_d   = '0;
          sel_d   = '0;
          y_d     = 1'b0;
          valid_d = 1'b0;
        end else if (cnt_q != LAST_CNT) begin
          cnt_d = cnt_q + CW'(1);
        end else if (sel_q != LAST_SEL) begin
          cnt_d = '0;
          sel_d = sel_inc;
          y_d   = shadow_q[sel_inc];
        end else begin
          done_d = 1'b1;
          cnt_d  = '0;
          sel_d  = '0;
          if (bus.load) begin
            shadow_d = bus.din;
            y_d      = bus.din[0];
            valid_d  = 1'b1;
            fs_d     = 1'b1;
          end else begin
            state_d = IDLE;
            y_d     = 1'b0;
            valid_d = 1'b0;
          end
        end
      end
    endcase

    // Registered ready must be high in the cycle where the next load is
    // acceptable: any idle cycle, or the final cycle of the last slot.
    ready_d = (state_d == IDLE) || ((sel_d == LAST_SEL) && (cnt_d == LAST_CNT));
  end

  assign bus.Y           = y_q;
  assign bus.sel         = sel_q;
  assign bus.valid       = valid_q;
  assign bus.frame_start = fs_q;
  assign bus.done        = done_q;
  assign bus.ready       = ready_q;

endmodule

// File: tb/tb_tdm_mux8_tx.sv
// Directed bench for tdm_mux8_tx: a per-cycle vector table on a 1-cycle-slot
// instance, a 3-cycle-slot frame sequence, and an asynchronous reset check.
module tb_tdm_mux8_tx;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  tdm_mux8_tx_if b1 ();
  tdm_mux8_tx_if b3 ();

  tdm_mux8_tx #(.SLOT_CYCLES(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(b1));
  tdm_mux8_tx #(.SLOT_CYCLES(3)) dut3 (.clk(clk), .rst_n(rst_n), .bus(b3));

  typedef struct {
    logic       en;
    logic       load;
    logic [7:0] din;
    logic [7:0] exp;   // {valid, sel[2:0], Y, frame_start, done, ready}
  } vec_t;

  vec_t vq[$];
  int   nvec = 0;
  int   nerr = 0;

  localparam logic [7:0] RST_OUT = 8'b0000_0001;

  function automatic logic [7:0] pk(input logic v, input logic [2:0] s, input logic y,
                                    input logic fs, input logic dn, input logic rdy);
    return {v, s, y, fs, dn, rdy};
  endfunction

  function automatic logic [7:0] got1();
    return {b1.valid, b1.sel, b1.Y, b1.frame_start, b1.done, b1.ready};
  endfunction

  function automatic logic [7:0] got3();
    return {b3.valid, b3.sel, b3.Y, b3.frame_start, b3.done, b3.ready};
  endfunction

  task automatic chk(input string nm, input logic [7:0] got, input logic [7:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got {valid,sel,Y,fs,done,ready}=%b_%b_%b%b%b%b want %b_%b_%b%b%b%b",
               nm, got[7], got[6:4], got[3], got[2], got[1], got[0],
               exp[7], exp[6:4], exp[3], exp[2], exp[1], exp[0]);
    end
  endtask

  task automatic add(input logic en, input logic ld, input logic [7:0] d, input logic [7:0] e);
    vec_t v;
    v.en = en; v.load = ld; v.din = d; v.exp = e;
    vq.push_back(v);
  endtask

  initial begin
    // Frame 8'hA5 from idle.
    add(1, 1, 8'hA5, pk(1, 0, 1, 1, 0, 0));
    add(1, 0, 8'h00, pk(1, 1, 0, 0, 0, 0));
    add(1, 0, 8'h00, pk(1, 2, 1, 0, 0, 0));
    add(1, 0, 8'h00, pk(1, 3, 0, 0, 0, 0));
    add(1, 0, 8'h00, pk(1, 4, 0, 0, 0, 0));
    add(1, 0, 8'h00, pk(1, 5, 1, 0, 0, 0));
    add(1, 0, 8'h00, pk(1, 6, 0, 0, 0, 0));
    add(1, 0, 8'h00, pk(1, 7, 1, 0, 0, 1));
    // Back-to-back load of 8'h0F in the last cycle of slot 7.
    add(1, 1, 8'h0F, pk(1, 0, 1, 1, 1, 0));
    // din toggles mid-frame and a load arrives while sel=2: both ignored.
    add(1, 0, 8'hFF, pk(1, 1, 1, 0, 0, 0));
    add(1, 0, 8'h55, pk(1, 2, 1, 0, 0, 0));
    add(1, 1, 8'h00, pk(1, 3, 1, 0, 0, 0));
    add(1, 0, 8'hAA, pk(1, 4, 0, 0, 0, 0));
    add(1, 0, 8'hFF, pk(1, 5, 0, 0, 0, 0));
    add(1, 0, 8'h00, pk(1, 6, 0, 0, 0, 0));
    add(1, 0, 8'hFF, pk(1, 7, 0, 0, 0, 1));
    add(1, 0, 8'h00, pk(0, 0, 0, 0, 1, 1));
    add(1, 0, 8'h00, pk(0, 0, 0, 0, 0, 1));
    // Load with EN=0 in idle is ignored, ready stays high.
    add(0, 1, 8'hFF, pk(0, 0, 0, 0, 0, 1));
    // Frame 8'hFF aborted by EN=0 sampled during sel=4.
    add(1, 1, 8'hFF, pk(1, 0, 1, 1, 0, 0));
    add(1, 0, 8'h00, pk(1, 1, 1, 0, 0, 0));
    add(1, 0, 8'h00, pk(1, 2, 1, 0, 0, 0));
    add(1, 0, 8'h00, pk(1, 3, 1, 0, 0, 0));
    add(1, 0, 8'h00, pk(1, 4, 1, 0, 0, 0));
    add(0, 0, 8'h00, pk(0, 0, 0, 0, 0, 1));
    // Fresh frame 8'h02 after the abort, run to completion.
    add(1, 1, 8'h02, pk(1, 0, 0, 1, 0, 0));
    add(1, 0, 8'h00, pk(1, 1, 1, 0, 0, 0));
    add(1, 0, 8'h00, pk(1, 2, 0, 0, 0, 0));
    add(1, 0, 8'h00, pk(1, 3, 0, 0, 0, 0));
    add(1, 0, 8'h00, pk(1, 4, 0, 0, 0, 0));
    add(1, 0, 8'h00, pk(1, 5, 0, 0, 0, 0));
    add(1, 0, 8'h00, pk(1, 6, 0, 0, 0, 0));
    add(1, 0, 8'h00, pk(1, 7, 0, 0, 0, 1));
    add(1, 0, 8'h00, pk(0, 0, 0, 0, 1, 1));

    b1.EN = 1'b1; b1.load = 1'b0; b1.din = 8'h00;
    b3.EN = 1'b1; b3.load = 1'b0; b3.din = 8'h00;

    #12;
    chk("reset1", got1(), RST_OUT);
    chk("reset3", got3(), RST_OUT);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("idle1", got1(), RST_OUT);

    // Table on the 1-cycle-slot instance.
    for (int i = 0; i < vq.size(); i++) begin
      @(negedge clk);
      b1.EN = vq[i].en; b1.load = vq[i].load; b1.din = vq[i].din;
      @(posedge clk); #1;
      chk($sformatf("vec%0d", i), got1(), vq[i].exp);
    end
    @(negedge clk);
    b1.EN = 1'b1; b1.load = 1'b0; b1.din = 8'h00;

    // 3-cycle slots, word 8'h81: 24-cycle frame, bit 1 only in slots 0 and 7.
    begin
      logic [2:0] s;
      b3.load = 1'b1; b3.din = 8'h81;
      for (int k = 0; k < 24; k++) begin
        @(posedge clk); #1;
        s = 3'(k / 3);
        chk($sformatf("slot3_c%0d", k), got3(),
            pk(1'b1, s, (s == 3'd0) || (s == 3'd7), k == 0, 1'b0, k == 23));
        @(negedge clk);
        b3.load = 1'b0; b3.din = ~b3.din;
      end
      @(posedge clk); #1;
      chk("slot3_done", got3(), pk(0, 0, 0, 0, 1, 1));
      @(posedge clk); #1;
      chk("slot3_after", got3(), pk(0, 0, 0, 0, 0, 1));
    end

    // Asynchronous reset between clock edges in the middle of a frame.
    @(negedge clk);
    b1.load = 1'b1; b1.din = 8'hA5;
    @(posedge clk); #1;
    chk("ar_start", got1(), pk(1, 0, 1, 1, 0, 0));
    @(negedge clk);
    b1.load = 1'b0;
    @(posedge clk); #1;
    chk("ar_sel1", got1(), pk(1, 1, 0, 0, 0, 0));
    #1 rst_n = 1'b0;
    #1;
    chk("ar_async", got1(), RST_OUT);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("ar_idle", got1(), RST_OUT);
    @(negedge clk);
    b1.load = 1'b1; b1.din = 8'h01;
    @(posedge clk); #1;
    chk("ar_restart", got1(), pk(1, 0, 1, 1, 0, 0));
    @(negedge clk);
    b1.load = 1'b0;
    @(posedge clk); #1;
    chk("ar_sel1b", got1(), pk(1, 1, 0, 0, 0, 0));

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  // Hard stop so the run can never hang.
  initial begin
    #100000;
    $display("FAIL timeout: simulation did not reach the summary, required completion");
    $fatal(1);
  end

endmodule
